// File: rtl/inst_fetch_buf_if.sv
// Memory-side bus of the instruction fetch line buffer.
//
// Signals:
//   mem_req    - read request valid (driven by the fetch buffer)
//   mem_addr   - line-aligned read address, held stable while mem_req is high
//   mem_gnt    - request accepted this cycle
//   mem_rvalid - read data valid
//   mem_rdata  - one line of read data; halfword 0 in bits [15:0]
//
// Modports:
//   master - fetch buffer side
//   slave  - instruction memory side
interface inst_fetch_buf_if #(
    parameter int unsigned LINEWIDTH = 64
);
    logic                 mem_req;
    logic [31:0]          mem_addr;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [LINEWIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/inst_fetch_buf.sv
// Instruction fetch line buffer.
//
// Issues line-aligned reads to instruction memory (one outstanding at a time), stores the
// returned halfwords in a circular FIFO and realigns mixed 16/32-bit instructions so that one
// instruction per cycle is presented to the PC/decode stage.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   rst_addr_i    - fetch start address after reset
//   flush_i       - redirect request (highest priority)
//   flush_addr_i  - redirect target, halfword aligned
//   stall_i       - consumer not accepting the current instruction
//   mem           - memory bus (inst_fetch_buf_if.master)
//   inst_valid_o  - inst_o holds a complete instruction
//   inst_o        - instruction; compressed ones zero-extended in [15:0]
//   is_rvc_o      - inst_o is a 16-bit instruction
//   inst_addr_o   - address of inst_o
//
// Parameters:
//   DEPTH     - FIFO capacity in halfwords (power of two, >= 2 lines)
//   LINEWIDTH - bits per memory response (multiple of 32, power of two for line alignment)
//
// Build option:
//   IBUF_BYPASS_EN - when defined, a response arriving at an empty FIFO presents its first
//                    instruction combinationally in the same cycle; an accepted bypassed
//                    instruction is not written into the FIFO. When undefined, response to
//                    output latency is always one cycle.
module inst_fetch_buf #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned LINEWIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      rst_addr_i,
    input  logic             flush_i,
    input  logic [31:0]      flush_addr_i,
    input  logic             stall_i,
    inst_fetch_buf_if.master mem,
    output logic             inst_valid_o,
    output logic [31:0]      inst_o,
    output logic             is_rvc_o,
    output logic [31:0]      inst_addr_o
);

    localparam int unsigned HW_PER_LINE = LINEWIDTH / 16;
    localparam int unsigned LINE_BYTES  = LINEWIDTH / 8;
    localparam int unsigned OFF_W       = $clog2(LINE_BYTES);
    localparam int unsigned HW_IDX_W    = OFF_W - 1;
    localparam int unsigned PTR_W       = $clog2(DEPTH);
    localparam int unsigned CNT_W       = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HW_C    = CNT_W'(HW_PER_LINE);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic                mem_req_q;
    logic                discard_q;
    logic [31:0]         fetch_addr_q;
    logic [HW_IDX_W-1:0] drop_q;
    logic [31:0]         inst_addr_q;
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [15:0]         fifo_q [DEPTH];

    // ------------------------------------------------------------------
    // Response handling
    // ------------------------------------------------------------------
    logic [15:0]      line_hw [HW_PER_LINE];
    logic             rsp_take;
    logic [CNT_W-1:0] wr_start;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;

    for (genvar i = 0; i < HW_PER_LINE; i++) begin : g_line_hw
        assign line_hw[i] = mem.mem_rdata[16*i +: 16];
    end

    // A response is stored only if it belongs to the current fetch stream.
    assign rsp_take = (state_q == StWait) && mem.mem_rvalid && !discard_q && !flush_i;

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    logic [15:0] h0, h1;
    logic        fifo_rvc;
    logic        fifo_ok;
    logic        dec_valid;
    logic        dec_rvc;
    logic [31:0] dec_inst;
    logic        pop;
    logic [CNT_W-1:0] pop_n;
    logic        bypass;

    assign h0       = fifo_q[rd_ptr_q];
    assign h1       = fifo_q[rd_ptr_q + PTR_W'(1)];
    assign fifo_rvc = (h0[1:0] != 2'b11);
    assign fifo_ok  = fifo_rvc ? (count_q >= ONE_C) : (count_q >= TWO_C);

`ifdef IBUF_BYPASS_EN
    logic [15:0]      bh0, bh1;
    logic             b_rvc;
    logic             b_has_h1;
    logic [CNT_W-1:0] drop_ext;

    assign drop_ext = CNT_W'(drop_q);
    assign bh0      = line_hw[drop_q];
    // bh1 only matters when the first instruction does not start in the last halfword.
    assign b_has_h1 = (drop_ext + ONE_C) < HW_C;
    assign bh1      = b_has_h1 ? line_hw[drop_q + 1'b1] : 16'h0000;
    assign b_rvc    = (bh0[1:0] != 2'b11);
    assign bypass   = (count_q == '0) && rsp_take;

    always_comb begin
        dec_valid = fifo_ok;
        dec_rvc   = fifo_rvc;
        dec_inst  = fifo_rvc ? {16'h0000, h0} : {h1, h0};
        if (bypass) begin
            dec_valid = b_rvc || b_has_h1;
            dec_rvc   = b_rvc;
            dec_inst  = b_rvc ? {16'h0000, bh0} : {bh1, bh0};
        end
    end

    // A bypassed instruction that is accepted skips the FIFO.
    assign wr_start = CNT_W'(drop_q) + ((bypass && pop) ? pop_n : '0);
`else
    assign bypass    = 1'b0;
    assign dec_valid = fifo_ok;
    assign dec_rvc   = fifo_rvc;
    assign dec_inst  = fifo_rvc ? {16'h0000, h0} : {h1, h0};
    assign wr_start  = CNT_W'(drop_q);
`endif

    assign inst_valid_o = dec_valid;
    assign is_rvc_o     = dec_valid && dec_rvc;
    assign inst_o       = dec_valid ? dec_inst : 32'h0000_0000;
    assign inst_addr_o  = inst_addr_q;

    assign pop    = dec_valid && !stall_i && !flush_i;
    assign pop_n  = dec_rvc ? ONE_C : TWO_C;
    assign rd_cnt = (pop && !bypass) ? pop_n : '0;
    assign wr_cnt = rsp_take ? (HW_C - wr_start) : '0;

    always_comb begin
        count_d = count_q + wr_cnt - rd_cnt;
    end

    // ------------------------------------------------------------------
    // FIFO storage: entry j takes line halfword (j - wr_ptr) + wr_start
    // ------------------------------------------------------------------
    for (genvar j = 0; j < DEPTH; j++) begin : g_fifo
        logic [PTR_W-1:0] off;
        logic [CNT_W-1:0] src;

        assign off = PTR_W'(j) - wr_ptr_q;
        assign src = CNT_W'(off) + wr_start;

        always_ff @(posedge clk) begin
            if (CNT_W'(off) < wr_cnt) begin
                fifo_q[j] <= line_hw[src[HW_IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            inst_addr_q <= rst_addr_i;
        end else if (flush_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            inst_addr_q <= flush_addr_i;
        end else begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(rd_cnt);
            wr_ptr_q <= wr_ptr_q + PTR_W'(wr_cnt);
            count_q  <= count_d;
            if (pop) begin
                inst_addr_q <= inst_addr_q + (dec_rvc ? 32'd2 : 32'd4);
            end
        end
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    logic free_ok;
    logic free_ok_next;

    // Only request when a whole line fits, regardless of the drop offset.
    assign free_ok      = (DEPTH_C - count_q) >= HW_C;
    assign free_ok_next = (DEPTH_C - count_d) >= HW_C;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (free_ok) state_d = StReq;
            StReq:  if (mem.mem_gnt) state_d = StWait;
            StWait: if (mem.mem_rvalid) state_d = free_ok_next ? StReq : StIdle;
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            // Still waiting on a response after this cycle: keep waiting, it gets discarded.
            if ((state_q == StReq && mem.mem_gnt) || (state_q == StWait && !mem.mem_rvalid)) begin
                state_d = StWait;
            end else begin
                state_d = StReq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mem_req_q    <= 1'b0;
            discard_q    <= 1'b0;
            fetch_addr_q <= {rst_addr_i[31:OFF_W], {OFF_W{1'b0}}};
            drop_q       <= rst_addr_i[OFF_W-1:1];
        end else begin
            state_q   <= state_d;
            mem_req_q <= (state_d == StReq);
            if (flush_i) begin
                fetch_addr_q <= {flush_addr_i[31:OFF_W], {OFF_W{1'b0}}};
                drop_q       <= flush_addr_i[OFF_W-1:1];
                discard_q    <= (state_d == StWait);
            end else if (state_q == StWait && mem.mem_rvalid) begin
                discard_q <= 1'b0;
                if (!discard_q) begin
                    fetch_addr_q <= fetch_addr_q + 32'(LINE_BYTES);
                    drop_q       <= '0;
                end
            end
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = fetch_addr_q;

endmodule
